// File: rtl/countdown_seq_ctrl.sv
// Sequencer for the shared 4-bit loadable down-counter: load, prescaled decrements, done/reload.
// Latency: start_ack and counter latch one cycle after an accepted start; done N*(P+1)+3 cycles after start.
// Backpressure: none; start is only accepted in IDLE, stop aborts at once, pause freezes the countdown.
module countdown_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic             cnt_zero,
    output logic             cnt_latch,
    output logic             cnt_dec,
    output logic [WIDTH-1:0] cnt_in,
    output logic             start_ack,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [PS_W-1:0]  ps_reg;
    logic [PS_W-1:0]  ps_cnt;
    logic             mode_reg;
    logic             ps_hit;

    // Prescale terminal count; the compare fires at ps_reg, so ps_cnt never wraps.
    assign ps_hit = (ps_cnt == ps_reg);

    // Sequencer state, captured start parameters, prescale counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            reload_reg <= '0;
            ps_reg     <= '0;
            mode_reg   <= 1'b0;
            ps_cnt     <= '0;
            start_ack  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start together with stop is treated as no request at all
                    if (start && !stop) begin
                        reload_reg <= load_val;
                        ps_reg     <= prescale;
                        mode_reg   <= mode;
                        start_ack  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ps_cnt <= '0;
                        state  <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt_zero) begin
                        state <= S_DONE;
                    end else if (pause) begin
                        ps_cnt <= ps_cnt;
                    end else if (ps_hit) begin
                        ps_cnt <= '0;
                    end else begin
                        ps_cnt <= ps_cnt + PS_W'(1);
                    end
                end
                S_DONE: begin
                    if (stop || !mode_reg) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        // periodic mode reloads with the values captured at start
                        state <= S_LOAD;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Counter strobes and done pulse decoded from the current state; stop masks all of them.
    always_comb begin
        cnt_in    = reload_reg;
        cnt_latch = 1'b0;
        cnt_dec   = 1'b0;
        done      = 1'b0;
        if (!stop) begin
            case (state)
                S_LOAD:  cnt_latch = 1'b1;
                S_COUNT: cnt_dec   = !cnt_zero && !pause && ps_hit;
                S_DONE:  done      = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
module tb_countdown_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int PS_W  = 8;

    logic             clk = 1'b0;
    logic             rst, start, stop, pause, mode;
    logic [WIDTH-1:0] load_val;
    logic [PS_W-1:0]  prescale;
    logic             cnt_zero;
    logic             cnt_latch, cnt_dec, start_ack, busy, done;
    logic [WIDTH-1:0] cnt_in;

    countdown_seq_ctrl #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mode(mode),
        .load_val(load_val), .prescale(prescale), .cnt_zero(cnt_zero),
        .cnt_latch(cnt_latch), .cnt_dec(cnt_dec), .cnt_in(cnt_in),
        .start_ack(start_ack), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external down-counter datapath; it has no reset and keeps its value across aborts
    logic [WIDTH-1:0] cnt = '0;
    always @(posedge clk) begin
        if (cnt_latch)    cnt <= cnt_in;
        else if (cnt_dec) cnt <= cnt - WIDTH'(1);
    end
    assign cnt_zero = (cnt == '0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // event logs: cycle numbers in which each pulse was observed
    int ack_q[$], latch_q[$], dec_q[$], done_q[$], exp_q[$];

    // timeline model: m_r counts un-paused cycles since the start was accepted (1 = load cycle)
    bit m_en = 0, m_act = 0, m_first = 0, m_mode = 0;
    int m_r = 0, m_N = 0, m_P = 0;

    function automatic int m_len();
        return m_N * (m_P + 1) + 3;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_en = 1; m_act = 0; m_first = 0;
        end else if (!m_act) begin
            if (start && !stop) begin
                m_act = 1; m_r = 1; m_first = 1;
                m_N = int'(load_val); m_P = int'(prescale); m_mode = mode;
            end
        end else if (stop) begin
            m_act = 0;
        end else if (m_r == m_len()) begin
            if (m_mode) begin m_r = 1; m_first = 0; end
            else m_act = 0;
        end else if (!(m_r >= 2 && m_r < m_len() - 1 && pause)) begin
            m_r = m_r + 1;
        end
    end

    // per-cycle compare of all outputs against the timeline model, plus pulse logging
    initial forever begin
        logic [4:0] e, a;
        bit         dec_slot, bad;
        @(negedge clk);
        if (m_en) begin
            dec_slot = m_r >= 2 && m_r < m_len() - 1 && ((m_r - 2) % (m_P + 1)) == m_P;
            e = {m_act, m_act && m_r == 1 && m_first, m_act && !stop && m_r == 1,
                 m_act && !stop && !pause && dec_slot, m_act && !stop && m_r == m_len()};
            a = {busy, start_ack, cnt_latch, cnt_dec, done};
            bad = (a !== e) || (e[2] && cnt_in !== m_N[WIDTH-1:0]);
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL cycle_cmp @%0d: {busy,ack,latch,dec,done}=%b cnt_in=%0d, want %b cnt_in=%0d",
                         cyc, a, cnt_in, e, m_N);
            end
            if (start_ack) ack_q.push_back(cyc);
            if (cnt_latch) latch_q.push_back(cyc);
            if (cnt_dec)   dec_q.push_back(cyc);
            if (done)      done_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_logs();
        ack_q.delete(); latch_q.delete(); dec_q.delete(); done_q.delete();
    endtask

    task automatic expect3(input int x, input int y, input int z);
        exp_q.delete();
        if (x >= 0) exp_q.push_back(x);
        if (y >= 0) exp_q.push_back(y);
        if (z >= 0) exp_q.push_back(z);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // which: 0 = start_ack, 1 = cnt_latch, 2 = cnt_dec, 3 = done
    task automatic chk_log(input string name, input int which);
        int got[$];
        bit ok;
        case (which)
            0:       got = ack_q;
            1:       got = latch_q;
            2:       got = dec_q;
            default: got = done_q;
        endcase
        ok = (got.size() == exp_q.size());
        if (ok) foreach (got[i]) if (got[i] != exp_q[i]) ok = 0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: pulse cycles %p, want %p", name, got, exp_q);
        end
    endtask

    int t0;

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; mode = 0; load_val = '0; prescale = '0;
        repeat (2) tick();
        rst = 0;
        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_latch", cnt_latch, 0);
        chk("rst_dec", cnt_dec, 0);
        chk("rst_ack", start_ack, 0);
        chk("rst_cnt_in", cnt_in, 0);
        tick();

        // one-shot N=3 P=0
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd3; prescale = 8'd0; mode = 0;
        goto(t0 + 1); start = 0;
        chk("os_cnt_in", cnt_in, 3);
        goto(t0 + 6); chk("os_busy_done_cyc", busy, 1);
        goto(t0 + 7); chk("os_busy_after", busy, 0);
        goto(t0 + 10);
        expect3(t0 + 1, -1, -1);     chk_log("os_ack", 0);
        expect3(t0 + 1, -1, -1);     chk_log("os_latch", 1);
        expect3(t0 + 2, t0 + 3, t0 + 4); chk_log("os_dec", 2);
        expect3(t0 + 6, -1, -1);     chk_log("os_done", 3);

        // prescale 3 with two pause cycles mid-count
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd2; prescale = 8'd3; mode = 0;
        goto(t0 + 1); start = 0;
        goto(t0 + 6); pause = 1;
        goto(t0 + 8); pause = 0;
        goto(t0 + 16);
        expect3(t0 + 5, t0 + 11, -1); chk_log("ps_dec", 2);
        expect3(t0 + 13, -1, -1);     chk_log("ps_done", 3);

        // periodic N=1 P=1, stopped mid-count of the third period
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd1; prescale = 8'd1; mode = 1;
        goto(t0 + 1); start = 0;
        goto(t0 + 12); stop = 1;
        goto(t0 + 13); stop = 0;
        chk("per_busy_after_stop", busy, 0);
        goto(t0 + 20);
        expect3(t0 + 1, -1, -1);           chk_log("per_ack", 0);
        expect3(t0 + 1, t0 + 6, t0 + 11);  chk_log("per_latch", 1);
        expect3(t0 + 3, t0 + 8, -1);       chk_log("per_dec", 2);
        expect3(t0 + 5, t0 + 10, -1);      chk_log("per_done", 3);

        // zero load, with a start while busy that must be ignored
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd0; prescale = 8'd5; mode = 0;
        goto(t0 + 1); start = 0;
        goto(t0 + 2); start = 1; load_val = 4'd9; prescale = 8'd0; mode = 1;
        chk("zero_cnt_in_kept", cnt_in, 0);
        goto(t0 + 3); start = 0;
        goto(t0 + 8);
        expect3(t0 + 1, -1, -1); chk_log("zero_ack", 0);
        expect3(t0 + 1, -1, -1); chk_log("zero_latch", 1);
        expect3(-1, -1, -1);     chk_log("zero_dec", 2);
        expect3(t0 + 3, -1, -1); chk_log("zero_done", 3);

        // start together with stop in IDLE
        clear_logs(); t0 = cyc;
        start = 1; stop = 1; load_val = 4'd7; prescale = 8'd0; mode = 0;
        goto(t0 + 1); start = 0; stop = 0;
        goto(t0 + 4);
        chk("ss_busy", busy, 0);
        expect3(-1, -1, -1); chk_log("ss_ack", 0);
        expect3(-1, -1, -1); chk_log("ss_latch", 1);

        // reset while counting
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd5; prescale = 8'd2; mode = 0;
        goto(t0 + 1); start = 0;
        goto(t0 + 4); rst = 1;
        goto(t0 + 5); rst = 0;
        chk("mr_busy", busy, 0);
        chk("mr_latch", cnt_latch, 0);
        chk("mr_dec", cnt_dec, 0);
        chk("mr_done", done, 0);
        chk("mr_ack", start_ack, 0);
        chk("mr_cnt_in", cnt_in, 0);
        goto(t0 + 10);
        expect3(t0 + 4, -1, -1); chk_log("mr_dec_log", 2);
        expect3(-1, -1, -1);     chk_log("mr_done_log", 3);

        // fresh start after the reset reloads the counter
        clear_logs(); t0 = cyc;
        start = 1; load_val = 4'd2; prescale = 8'd0; mode = 0;
        goto(t0 + 1); start = 0;
        goto(t0 + 8);
        expect3(t0 + 1, -1, -1);     chk_log("re_latch", 1);
        expect3(t0 + 2, t0 + 3, -1); chk_log("re_dec", 2);
        expect3(t0 + 5, -1, -1);     chk_log("re_done", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
